// File: rtl/cci_mpf_shim_almfull_buf_n.sv
// Generic single-clock FIFO with registered count; caller guarantees push only when not full or popping.
// Latency: written entry visible on head_dat the cycle after push.
// Backpressure: none internally; push/pop gating is the caller's job.
module cci_mpf_shim_almfull_buf_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[head];

endmodule

// N-channel almost-full absorb buffer; CCI_MPF_ALMFULL_BUF_STATS_EN adds per-channel occupancy watermarks.
// Latency: 2 cycles afu_tx -> fiu_tx with an empty FIFO and fiu_tx_almfull low; no bypass.
// Backpressure: afu_tx_almfull at DEPTH-ALMFULL_SLACK entries; fiu_tx_almfull stalls drain; requests into a full FIFO drop and set err_overflow.
module cci_mpf_shim_almfull_buf_n #(
    parameter int N_CHANNELS    = 2,
    parameter int REQ_WIDTH     = 600,
    parameter int DEPTH         = 16,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [N_CHANNELS-1:0]                  afu_tx_valid,
    input  logic [N_CHANNELS*REQ_WIDTH-1:0]        afu_tx_data,
    output logic [N_CHANNELS-1:0]                  afu_tx_almfull,
    output logic [N_CHANNELS-1:0]                  fiu_tx_valid,
    output logic [N_CHANNELS*REQ_WIDTH-1:0]        fiu_tx_data,
    input  logic [N_CHANNELS-1:0]                  fiu_tx_almfull,
    output logic [N_CHANNELS*($clog2(DEPTH)+1)-1:0] occupancy,
    output logic [N_CHANNELS-1:0]                  err_overflow,
    output logic [N_CHANNELS*($clog2(DEPTH)+1)-1:0] max_occupancy
);
    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL    = CW'(DEPTH);
    localparam logic [CW-1:0]  THRESH  = CW'(DEPTH - ALMFULL_SLACK);

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        logic [REQ_WIDTH-1:0] in_dat;
        logic [REQ_WIDTH-1:0] head_dat;
        logic [REQ_WIDTH-1:0] out_dat;
        logic [CW-1:0]        cnt;
        logic [CW-1:0]        next_cnt;
        logic                 pop;
        logic                 push;
        logic                 out_vld;
        logic                 almfull_q;
        logic                 ovf_q;

        assign in_dat   = afu_tx_data[i*REQ_WIDTH +: REQ_WIDTH];
        assign pop      = (cnt != '0) && !fiu_tx_almfull[i];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        assign push     = afu_tx_valid[i] && ((cnt != FULL) || pop);
        assign next_cnt = cnt + CW'(push) - CW'(pop);

        cci_mpf_shim_almfull_buf_fifo #(
            .W     (REQ_WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset_n  (reset_n),
            .push     (push),
            .push_dat (in_dat),
            .pop      (pop),
            .head_dat (head_dat),
            .cnt      (cnt)
        );

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_vld   <= 1'b0;
                almfull_q <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                out_vld   <= pop;
                almfull_q <= (next_cnt >= THRESH);
                if (afu_tx_valid[i] && !push) begin
                    ovf_q <= 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (pop) begin
                out_dat <= head_dat;
            end
        end

        assign fiu_tx_valid[i]                        = out_vld;
        assign fiu_tx_data[i*REQ_WIDTH +: REQ_WIDTH]  = out_dat;
        assign afu_tx_almfull[i]                      = almfull_q;
        assign err_overflow[i]                        = ovf_q;
        assign occupancy[i*CW +: CW]                  = cnt;

`ifdef CCI_MPF_ALMFULL_BUF_STATS_EN
        logic [CW-1:0] max_q;

        // next_cnt never exceeds DEPTH, so the watermark saturates on its own.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                max_q <= '0;
            end else if (next_cnt > max_q) begin
                max_q <= next_cnt;
            end
        end

        assign max_occupancy[i*CW +: CW] = max_q;
`else
        assign max_occupancy[i*CW +: CW] = '0;
`endif
    end

endmodule

// File: tb/tb_cci_mpf_shim_almfull_buf_n.sv
// Randomised and directed bench for cci_mpf_shim_almfull_buf_n against a queue-based channel model.
`timescale 1ns/1ps
module tb_cci_mpf_shim_almfull_buf_n;
    localparam int N     = 2;
    localparam int RW    = 600;
    localparam int DEPTH = 16;
    localparam int SLACK = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef logic [RW-1:0] req_t;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b1;
    logic [N-1:0]   afu_tx_valid   = '0;
    logic [N*RW-1:0] afu_tx_data   = '0;
    logic [N-1:0]   afu_tx_almfull;
    logic [N-1:0]   fiu_tx_valid;
    logic [N*RW-1:0] fiu_tx_data;
    logic [N-1:0]   fiu_tx_almfull = '0;
    logic [N*CW-1:0] occupancy;
    logic [N-1:0]   err_overflow;
    logic [N*CW-1:0] max_occupancy;

    always #5 clk = ~clk;

    cci_mpf_shim_almfull_buf_n #(
        .N_CHANNELS    (N),
        .REQ_WIDTH     (RW),
        .DEPTH         (DEPTH),
        .ALMFULL_SLACK (SLACK)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .afu_tx_valid   (afu_tx_valid),
        .afu_tx_data    (afu_tx_data),
        .afu_tx_almfull (afu_tx_almfull),
        .fiu_tx_valid   (fiu_tx_valid),
        .fiu_tx_data    (fiu_tx_data),
        .fiu_tx_almfull (fiu_tx_almfull),
        .occupancy      (occupancy),
        .err_overflow   (err_overflow),
        .max_occupancy  (max_occupancy)
    );

    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: one queue per channel plus the expected output register.
    req_t q [N][$];
    logic m_vld [N];
    req_t m_dat [N];
    logic m_ovf [N];
    int   m_max [N];
    int   seen  [N];

    task automatic chk(input string tag, input req_t got, input req_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic req_t rnd_req();
        req_t r;
        r = '0;
        for (int k = 0; k < (RW + 31) / 32; k++) begin
            r = (r << 32) | req_t'($urandom);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            m_vld[i] = 1'b0;
            m_ovf[i] = 1'b0;
            m_max[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            if (q[i].size() > 0 && !fiu_tx_almfull[i]) begin
                m_dat[i] = q[i].pop_front();
                m_vld[i] = 1'b1;
            end
            if (afu_tx_valid[i]) begin
                if (q[i].size() < DEPTH) q[i].push_back(afu_tx_data[i*RW +: RW]);
                else m_ovf[i] = 1'b1;
            end
            if (q[i].size() > m_max[i]) m_max[i] = q[i].size();
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fiu_valid%0d", i), req_t'(fiu_tx_valid[i]), req_t'(m_vld[i]));
            if (m_vld[i]) chk($sformatf("fiu_data%0d", i), fiu_tx_data[i*RW +: RW], m_dat[i]);
            chk($sformatf("occ%0d", i), req_t'(occupancy[i*CW +: CW]), req_t'(q[i].size()));
            chk($sformatf("almfull%0d", i), req_t'(afu_tx_almfull[i]),
                req_t'(q[i].size() >= DEPTH - SLACK));
            chk($sformatf("ovf%0d", i), req_t'(err_overflow[i]), req_t'(m_ovf[i]));
`ifdef CCI_MPF_ALMFULL_BUF_STATS_EN
            chk($sformatf("maxocc%0d", i), req_t'(max_occupancy[i*CW +: CW]), req_t'(m_max[i]));
`else
            chk($sformatf("maxocc%0d", i), req_t'(max_occupancy[i*CW +: CW]), req_t'(0));
`endif
            if (fiu_tx_valid[i]) seen[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), req_t'(fiu_tx_valid[i]), req_t'(0));
            chk($sformatf("%s_occ%0d", tag, i), req_t'(occupancy[i*CW +: CW]), req_t'(0));
            chk($sformatf("%s_almfull%0d", tag, i), req_t'(afu_tx_almfull[i]), req_t'(0));
            chk($sformatf("%s_ovf%0d", tag, i), req_t'(err_overflow[i]), req_t'(0));
            chk($sformatf("%s_maxocc%0d", tag, i), req_t'(max_occupancy[i*CW +: CW]), req_t'(0));
        end
    endtask

    // Assert reset between clock edges and check outputs clear before the next edge.
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("arst");
        model_clear();
        afu_tx_valid = '0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        afu_tx_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        model_clear();
        for (int i = 0; i < N; i++) seen[i] = 0;

        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        #2 reset_n = 1'b1;

        // Basic passthrough: ch0 request in cycle 10 emerges exactly two edges later.
        idle(9);
        afu_tx_valid[0] = 1'b1;
        afu_tx_data[0 +: RW] = {75{8'hA5}};
        step();
        afu_tx_valid = '0;
        chk("lat_t1_valid", req_t'(fiu_tx_valid[0]), req_t'(0));
        step();
        chk("lat_t2_valid", req_t'(fiu_tx_valid[0]), req_t'(1));
        chk("lat_t2_data", fiu_tx_data[0 +: RW], {75{8'hA5}});
        chk("lat_ch1_idle", req_t'(fiu_tx_valid[1]), req_t'(0));
        step();
        chk("lat_t3_valid", req_t'(fiu_tx_valid[0]), req_t'(0));
        chk("lat_occ0", req_t'(occupancy[0 +: CW]), req_t'(0));

        // Almost-full threshold, then overflow on the 17th push.
        fiu_tx_almfull = 2'b01;
        for (int k = 0; k < 17; k++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[0 +: RW] = req_t'(100 + k);
            step();
            if (k == 6) chk("thr_before", req_t'(afu_tx_almfull[0]), req_t'(0));
            if (k == 7) begin
                chk("thr_after", req_t'(afu_tx_almfull[0]), req_t'(1));
                chk("thr_occ", req_t'(occupancy[0 +: CW]), req_t'(8));
            end
            if (k == 15) chk("ovf_before", req_t'(err_overflow[0]), req_t'(0));
        end
        chk("ovf_set", req_t'(err_overflow[0]), req_t'(1));
        afu_tx_valid = '0;
        fiu_tx_almfull = '0;
        seen[0] = 0;
        idle(20);
        chk("ovf_drain16", req_t'(seen[0]), req_t'(16));
        chk("ovf_sticky", req_t'(err_overflow[0]), req_t'(1));
        do_reset();

        // Full plus concurrent pop: the push is accepted.
        fiu_tx_almfull = 2'b01;
        for (int k = 0; k < 16; k++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[0 +: RW] = req_t'(200 + k);
            step();
        end
        fiu_tx_almfull = '0;
        afu_tx_data[0 +: RW] = req_t'(216);
        step();
        chk("fullpop_ovf", req_t'(err_overflow[0]), req_t'(0));
        chk("fullpop_occ", req_t'(occupancy[0 +: CW]), req_t'(16));
        seen[0] = 1;
        idle(20);
        chk("fullpop_drain17", req_t'(seen[0]), req_t'(17));
        do_reset();

        // Pointer wrap on ch1 while ch0 is blocked with 3 entries.
        fiu_tx_almfull = 2'b01;
        for (int k = 0; k < 3; k++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[0 +: RW] = req_t'(300 + k);
            step();
        end
        afu_tx_valid[0] = 1'b0;
        seen[1] = 0;
        for (int k = 0; k < 40; k++) begin
            afu_tx_valid[1] = 1'b1;
            afu_tx_data[RW +: RW] = req_t'(k);
            step();
        end
        idle(3);
        chk("wrap_seen40", req_t'(seen[1]), req_t'(40));
        chk("wrap_occ0", req_t'(occupancy[0 +: CW]), req_t'(3));

        // Async reset with 5 entries buffered.
        for (int k = 0; k < 2; k++) begin
            afu_tx_valid[0] = 1'b1;
            afu_tx_data[0 +: RW] = req_t'(303 + k);
            step();
        end
        afu_tx_valid = '0;
        chk("pre_rst_occ", req_t'(occupancy[0 +: CW]), req_t'(5));
`ifdef CCI_MPF_ALMFULL_BUF_STATS_EN
        chk("pre_rst_max", req_t'(max_occupancy[0 +: CW]), req_t'(5));
`endif
        do_reset();
        fiu_tx_almfull = '0;

        // Random traffic with occasional mid-stream resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                afu_tx_valid[i]   = ($urandom_range(0, 99) < 60);
                fiu_tx_almfull[i] = ($urandom_range(0, 99) < 35);
                afu_tx_data[i*RW +: RW] = rnd_req();
            end
            step();
            if ($urandom_range(0, 599) == 0) do_reset();
        end
        idle(DEPTH + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cci_mpf_shim_almfull_buf_n.md
Name: cci_mpf_shim_almfull_buf_n

Overview:
- Parametrised N-channel request buffer between AFU-side and FIU-side MPF TX channels.
- Absorbs requests issued after the downstream almost-full flag asserts.
- Regenerates an upstream almost-full per channel from local occupancy.
- Generalises the fixed c0Tx/c1Tx pair to N_CHANNELS independent channels of arbitrary request width, each with its own FIFO, flow control and overflow detection.

Parameters:
N_CHANNELS, 2, number of independent request channels (>=1)
REQ_WIDTH, 600, bits per request payload
DEPTH, 16, FIFO entries per channel; power of 2, >=4
ALMFULL_SLACK, 8, free entries reserved for in-flight requests; 1 <= ALMFULL_SLACK < DEPTH

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
afu_tx_valid  in  N_CHANNELS  request valid per channel
afu_tx_data  in  N_CHANNELS*REQ_WIDTH  request payloads; channel i at bits [i*REQ_WIDTH +: REQ_WIDTH]
afu_tx_almfull  out  N_CHANNELS  upstream almost-full per channel
fiu_tx_valid  out  N_CHANNELS  forwarded request valid
fiu_tx_data  out  N_CHANNELS*REQ_WIDTH  forwarded payloads, same packing
fiu_tx_almfull  in  N_CHANNELS  downstream almost-full per channel
occupancy  out  N_CHANNELS*($clog2(DEPTH)+1)  current entry count per channel
err_overflow  out  N_CHANNELS  sticky overflow flag per channel
max_occupancy  out  N_CHANNELS*($clog2(DEPTH)+1)  watermark (see Optional Feature)

Behaviour:
- Reset: one clock domain. reset_n is asynchronous, active-low. On assertion, immediately clear the following, then hold them until deassertion: all FIFO pointers and counts, fiu_tx_valid, afu_tx_almfull, occupancy, err_overflow, max_occupancy. fiu_tx_data reset value is don't-care; bench checks it only when valid is set. Reset mid-operation discards all buffered and in-output-register requests.
- Channels are fully independent; no cross-channel arbitration or ordering.
- Enqueue: on the rising edge, if afu_tx_valid[i] and count < DEPTH, write the payload at the tail and increment the tail (wraps modulo DEPTH).
- Overflow: if afu_tx_valid[i] and count == DEPTH with no dequeue in that cycle, drop the request, set err_overflow[i], and leave it set until reset.
- Dequeue: on each edge, if count > 0 and fiu_tx_almfull[i] == 0, load the head into the output register, set fiu_tx_valid[i]=1 and advance the head. Otherwise set fiu_tx_valid[i]=0.
- fiu_tx_valid is a one-cycle pulse per request; there is no hold or retry. The downstream almost-full is advisory, sampled the same cycle.
- Latency: a request presented in cycle t appears on fiu_tx_* in cycle t+2 at minimum (empty FIFO, almfull low). There is no bypass path.
- Simultaneous enqueue and dequeue: count unchanged. Full plus dequeue in the same cycle: the enqueue is accepted (the pop frees the slot), so there is no overflow.
- Count arithmetic: $clog2(DEPTH)+1 bits, range 0..DEPTH. occupancy is the registered count.
- afu_tx_almfull[i]: registered; equals 1 when next_count >= DEPTH-ALMFULL_SLACK, else 0. It is valid the cycle after the count change.
- Ordering: strict FIFO per channel; payload bits are passed unmodified.

Optional Feature:
- Macro: CCI_MPF_ALMFULL_BUF_STATS_EN.
- Defined: max_occupancy[i] is registered and updates to next_count whenever next_count exceeds its current value. It is cleared only by reset and saturates at DEPTH.
- Undefined: max_occupancy is tied to 0 and no watermark registers are instantiated. All other behaviour is identical.

Test Plan:
- Basic passthrough, N_CHANNELS=2, DEPTH=16, SLACK=8:
  - Stimulus: ch0 valid in cycle 10 with data 0xA5.., fiu_tx_almfull=0.
  - Expected: fiu_tx_valid[0]=1 with 0xA5.. in cycle 12 only; ch1 stays idle; occupancy[0] returns to 0.
- Almost-full threshold:
  - Stimulus: hold fiu_tx_almfull[0]=1 and push 8 requests back-to-back.
  - Expected: afu_tx_almfull[0] rises the cycle after the 8th enqueue; occupancy[0]=8; no fiu_tx_valid.
- Overflow:
  - Stimulus: with fiu_tx_almfull[0]=1, push 17 requests.
  - Expected: the 17th is dropped, err_overflow[0]=1 and stays 1; releasing almfull drains exactly 16 requests in order.
- Full plus concurrent pop:
  - Stimulus: with count=16, release almfull and push in the same cycle.
  - Expected: no overflow; count stays 16; 17 distinct payloads emerge in order.
- Pointer wrap and independence:
  - Stimulus: stream 40 sequential payloads on ch1 while ch0 is blocked.
  - Expected: ch1 outputs 0..39 in order; ch0 occupancy stays unchanged.
- Async reset mid-stream:
  - Stimulus: drop reset_n between clock edges with 5 entries buffered.
  - Expected: fiu_tx_valid, occupancy, afu_tx_almfull, err_overflow and max_occupancy read 0 immediately; with CCI_MPF_ALMFULL_BUF_STATS_EN defined, max_occupancy was 5 before reset.
